// File: rtl/booth_mul_arbiter_if.sv
// rtl/booth_mul_arbiter_if.sv - requester and multiplier bus of the shared booth multiplier arbiter
interface booth_mul_arbiter_if #(
    parameter int BIT_LEN = 4,
    parameter int REQ_N   = 4
);
    logic [REQ_N-1:0]         req;
    logic [REQ_N*BIT_LEN-1:0] in1_bus;
    logic [REQ_N*BIT_LEN-1:0] in2_bus;
    logic [REQ_N-1:0]         gnt;
    logic [REQ_N-1:0]         done;
    logic [2*BIT_LEN-1:0]     out;
    logic                     err;
    logic                     mul_rstn;
    logic                     mul_start;
    logic [BIT_LEN-1:0]       mul_in1;
    logic [BIT_LEN-1:0]       mul_in2;
    logic [2*BIT_LEN-1:0]     mul_out;
    logic                     mul_out_r;

    // Arbiter side: sees requests and the multiplier result, drives grants and the multiplier.
    modport slave (
        input  req, in1_bus, in2_bus, mul_out, mul_out_r,
        output gnt, done, out, err, mul_rstn, mul_start, mul_in1, mul_in2
    );

    // Environment side: requesters plus the multiplier itself.
    modport master (
        output req, in1_bus, in2_bus, mul_out, mul_out_r,
        input  gnt, done, out, err, mul_rstn, mul_start, mul_in1, mul_in2
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sequencer sharing one booth multiplier among REQ_N requesters
module booth_mul_arbiter #(
    parameter int BIT_LEN = 4,
    parameter int REQ_N   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    booth_mul_arbiter_if.slave   bus
);
    localparam int PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BIT_LEN-1:0] MOST_NEG = {1'b1, {(BIT_LEN-1){1'b0}}};
    localparam logic [TW-1:0]      TMR_LAST = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [TW-1:0]        timer;
    logic [REQ_N-1:0]     gnt_q;
    logic [REQ_N-1:0]     done_q;
    logic [2*BIT_LEN-1:0] out_q;
    logic                 err_q;
    logic                 mul_rstn_q;
    logic                 mul_start_q;
    logic [BIT_LEN-1:0]   in1_q;
    logic [BIT_LEN-1:0]   in2_q;

    logic [BIT_LEN-1:0]   in1_arr [REQ_N];
    logic [BIT_LEN-1:0]   in2_arr [REQ_N];
    logic [PW-1:0]        hi_pick;
    logic [PW-1:0]        lo_pick;
    logic                 hi_found;
    logic [PW-1:0]        pick;

    // Unpack the per-requester operand buses.
    always_comb begin
        for (int j = 0; j < REQ_N; j++) begin
            in1_arr[j] = bus.in1_bus[j*BIT_LEN +: BIT_LEN];
            in2_arr[j] = bus.in2_bus[j*BIT_LEN +: BIT_LEN];
        end
    end

    // Round-robin pick: lowest requester above ptr, else lowest at or below ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int j = REQ_N - 1; j >= 0; j--) begin
            if (bus.req[j]) begin
                if (j > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_pick  = PW'(j);
                end else begin
                    lo_pick  = PW'(j);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    // Sequencer: accept, clear the multiplier, run it, report; timer counts RUN cycles already spent.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= PW'(REQ_N - 1);
            timer       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
            mul_rstn_q  <= 1'b0;
            mul_start_q <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        ptr   <= pick;
                        in1_q <= in1_arr[pick];
                        in2_q <= in2_arr[pick];
                        gnt_q <= REQ_N'(1) << pick;
                        state <= CLR;
                    end
                end
                CLR: begin
                    gnt_q <= '0;
                    timer <= '0;
                    if (in1_q == MOST_NEG) begin
                        // The booth recoding cannot handle this multiplicand; report without running.
                        done_q <= REQ_N'(1) << ptr;
                        err_q  <= 1'b1;
                        out_q  <= '0;
                        state  <= DONE;
                    end else begin
                        mul_rstn_q  <= 1'b1;
                        mul_start_q <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (bus.mul_out_r) begin
                        // A result arriving on the abort edge still counts as good.
                        out_q       <= bus.mul_out;
                        err_q       <= 1'b0;
                        done_q      <= REQ_N'(1) << ptr;
                        mul_rstn_q  <= 1'b0;
                        mul_start_q <= 1'b0;
                        state       <= DONE;
                    end else if (timer == TMR_LAST) begin
                        out_q       <= '0;
                        err_q       <= 1'b1;
                        done_q      <= REQ_N'(1) << ptr;
                        mul_rstn_q  <= 1'b0;
                        mul_start_q <= 1'b0;
                        state       <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    done_q <= '0;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.out       = out_q;
    assign bus.err       = err_q;
    assign bus.mul_rstn  = mul_rstn_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_in1   = in1_q;
    assign bus.mul_in2   = in2_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - table-driven and randomized self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;
    localparam int BL  = 4;
    localparam int RN  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    booth_mul_arbiter_if #(.BIT_LEN(BL), .REQ_N(RN)) bus ();
    booth_mul_arbiter #(.BIT_LEN(BL), .REQ_N(RN), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int mul_lat = 1;
    int mul_cnt = 0;
    int last = RN - 1;

    typedef struct {
        int         k;
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
        logic       e;
        logic [7:0] o;
    } vec_t;
    vec_t tbl [11];

    function automatic logic [7:0] sprod(input logic [3:0] a, input logic [3:0] b);
        int x;
        x = $signed(a) * $signed(b);
        return x[7:0];
    endfunction

    function automatic int rr_pick(input logic [3:0] r);
        for (int i = 1; i <= RN; i++)
            if (r[(last + i) % RN]) return (last + i) % RN;
        return -1;
    endfunction

    // Behavioural multiplier: answers mul_lat started cycles after a clear; mul_lat 0 never answers.
    always @(posedge clk) begin
        if (!bus.mul_rstn) begin
            mul_cnt       <= 0;
            bus.mul_out_r <= 1'b0;
            bus.mul_out   <= 8'h00;
        end else if (bus.mul_start) begin
            mul_cnt <= mul_cnt + 1;
            if (mul_lat != 0 && mul_cnt + 1 == mul_lat) begin
                bus.mul_out_r <= 1'b1;
                bus.mul_out   <= sprod(bus.mul_in1, bus.mul_in2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [3:0] a, input logic [3:0] b);
        bus.in1_bus[k*BL +: BL] = a;
        bus.in2_bus[k*BL +: BL] = b;
    endtask

    task automatic wait_gnt(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 300) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL gnt_wait actual=none expected=grant within 300 cycles");
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.gnt, bus.done, bus.out, 5'(bus.err), bus.mul_in1, bus.mul_in2},
              32'h0);
        check({name, "_mul_ctl"}, {30'h0, bus.mul_start, bus.mul_rstn}, 32'h0);
    endtask

    // One full operation: predicted winner, latched operands, done latency, flags and product.
    task automatic transact(input bit drop, input int lat, output int w, output logic [3:0] g,
                            output logic [7:0] o, output logic e);
        bit ok, rs_hi, ovl, exp_err;
        int gap, exp_gap;
        logic [3:0] a, b;
        logic [7:0] exp_out;
        mul_lat = lat;
        w = -1; g = '0; o = '0; e = 1'b0;
        wait_gnt(ok);
        if (!ok) return;
        w = rr_pick(bus.req);
        g = bus.gnt;
        check("gnt_winner", 32'(bus.gnt), 32'(1) << w);
        a = bus.in1_bus[w*BL +: BL];
        b = bus.in2_bus[w*BL +: BL];
        check("mul_in1", 32'(bus.mul_in1), 32'(a));
        check("mul_in2", 32'(bus.mul_in2), 32'(b));
        last = w;
        if (drop) bus.req[w] = 1'b0;
        exp_err = (a == 4'b1000) || (lat == 0) || (lat > TMO);
        exp_out = exp_err ? 8'h00 : sprod(a, b);
        exp_gap = (a == 4'b1000) ? 1 : (exp_err ? TMO + 2 : lat + 2);
        gap = 0; rs_hi = 1'b0; ovl = 1'b0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) check("gnt_width", 32'(bus.gnt), 32'h0);
            if (bus.mul_rstn) rs_hi = 1'b1;
            if (bus.gnt != 0 && bus.done != 0) ovl = 1'b1;
        end while (bus.done == 0 && gap < 300);
        check("done_gap", 32'(gap), 32'(exp_gap));
        check("done_onehot", 32'(bus.done), 32'(1) << w);
        check("err", 32'(bus.err), 32'(exp_err));
        check("out", 32'(bus.out), 32'(exp_out));
        if (a == 4'b1000) check("mul_rstn_on_bad", 32'(rs_hi), 32'h0);
        check("gnt_done_overlap", 32'(ovl), 32'h0);
        o = bus.out;
        e = bus.err;
    endtask

    initial begin
        int w, gap;
        bit ok;
        logic [3:0] g;
        logic [7:0] o;
        logic e;

        tbl[0]  = '{2, 4'd3, 4'hE, 2,       1'b0, 8'hFA};
        tbl[1]  = '{1, 4'h8, 4'd5, 2,       1'b1, 8'h00};
        tbl[2]  = '{0, 4'd2, 4'd3, 0,       1'b1, 8'h00};
        tbl[3]  = '{3, 4'd7, 4'd7, 1,       1'b0, 8'h31};
        tbl[4]  = '{3, 4'hF, 4'h8, 3,       1'b0, 8'h08};
        tbl[5]  = '{0, 4'd7, 4'h8, 2,       1'b0, 8'hC8};
        tbl[6]  = '{2, 4'h9, 4'h9, 4,       1'b0, 8'h31};
        tbl[7]  = '{1, 4'd5, 4'hD, TMO,     1'b0, 8'hF1};
        tbl[8]  = '{0, 4'd2, 4'd3, TMO + 1, 1'b1, 8'h00};
        tbl[9]  = '{2, 4'd0, 4'd5, 1,       1'b0, 8'h00};
        tbl[10] = '{1, 4'd4, 4'd4, 5,       1'b0, 8'h10};

        bus.req = '0;
        bus.in1_bus = '0;
        bus.in2_bus = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        rstn = 1'b1;

        // All four requesting and held: strict rotation starting at 0.
        for (int k = 0; k < RN; k++) set_ops(k, 4'(k + 1), 4'(3 - k));
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            transact(1'b0, 2, w, g, o, e);
            check("rr_order", 32'(g), 32'(1) << (i % RN));
        end
        bus.req = '0;

        // Directed vectors: sign cases, illegal operand, stubbed multiplier, timeout boundary.
        for (int i = 0; i < 11; i++) begin
            bus.req = 4'(1 << tbl[i].k);
            set_ops(tbl[i].k, tbl[i].a, tbl[i].b);
            transact(1'b1, tbl[i].lat, w, g, o, e);
            check("vec_gnt", 32'(g), 32'(1) << tbl[i].k);
            check("vec_out", 32'(o), 32'(tbl[i].o));
            check("vec_err", 32'(e), 32'(tbl[i].e));
            @(negedge clk);
            check("out_hold", 32'(bus.out), 32'(tbl[i].o));
            check("done_width", 32'(bus.done), 32'h0);
        end

        // Asynchronous reset in the middle of RUN.
        set_ops(2, 4'd3, 4'd5);
        bus.req = 4'b0100;
        mul_lat = 10;
        wait_gnt(ok);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero("reset_in_run");
        set_ops(1, 4'd6, 4'd2);
        set_ops(3, 4'd1, 4'd1);
        bus.req = 4'b1010;
        repeat (2) @(negedge clk);
        check("reset_no_done", 32'(bus.done), 32'h0);
        rstn = 1'b1;
        last = RN - 1;
        transact(1'b1, 2, w, g, o, e);
        check("post_reset_gnt", 32'(g), 32'h2);
        transact(1'b1, 1, w, g, o, e);
        check("post_reset_gnt2", 32'(g), 32'h8);

        // Requester 3 raises and withdraws before arbitration: never served.
        set_ops(2, 4'd2, 4'd2);
        bus.req = 4'b0100;
        mul_lat = 6;
        wait_gnt(ok);
        check("drop_first_gnt", 32'(bus.gnt), 32'h4);
        last = 2;
        bus.req = '0;
        @(negedge clk);
        set_ops(3, 4'd5, 4'd5);
        bus.req[3] = 1'b1;
        repeat (2) @(negedge clk);
        bus.req[3] = 1'b0;
        set_ops(0, 4'hD, 4'd3);
        bus.req[0] = 1'b1;
        gap = 0;
        while (bus.done == 0 && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        check("drop_done", 32'(bus.done), 32'h4);
        check("drop_out", 32'(bus.out), 32'h04);
        transact(1'b1, 1, w, g, o, e);
        check("drop_next_gnt", 32'(g), 32'h1);

        // Randomized phases against the round-robin and arithmetic model.
        for (int p = 0; p < 12; p++) begin
            logic [3:0] m;
            bit hold;
            int n;
            m    = 4'($urandom_range(1, 15));
            hold = 1'($urandom_range(0, 1));
            for (int k = 0; k < RN; k++) set_ops(k, 4'($urandom), 4'($urandom));
            bus.req = m;
            n = 0;
            while (n < 6 && bus.req != 0) begin
                transact(!hold, int'($urandom_range(1, 6)), w, g, o, e);
                n++;
                if (w < 0) break;
            end
            bus.req = '0;
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
